dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//  Memory-stage data-bus controller; sits directly upstream of the load size converter (sizeconvld).
//  Turns a load/store in M into a word-aligned bus transaction with byte enables and lane-replicated store data.
//  Stalls the pipeline until ack or timeout, then presents the raw word (ReadDataMTick) and ByteNumM to the converter.
//  Flags misaligned accesses, reserved size codes and bus timeouts.
// PARAMETERS
//  TIMEOUT  16  max REQ cycles without BusAck before abort; legal range 1..255
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high
//  MemReadM       in   1   load in M stage
//  MemWriteM      in   1   store in M stage
//  LoadSizeM      in   3   000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101-111 reserved
//  StoreSizeM     in   2   00 sw, 01 sb, 10 sh; 11 reserved
//  ALUResultM     in   32  byte address
//  WriteDataM     in   32  store data, right-justified
//  StallM         out  1   hold F/D/E/M pipeline registers
//  ReadDataMTick  out  32  raw loaded word, feeds the size converter
//  ByteNumM       out  2   latched ALUResultM[1:0] of the last launched access
//  MisalignM      out  1   access rejected (misaligned or reserved size)
//  BusErrM        out  1   one-cycle pulse on timeout
//  BusReq         out  1   bus request
//  BusWe          out  1   1 = write
//  BusAddr        out  32  {addr[31:2],2'b00}
//  BusBE          out  4   byte enables (all 1 for reads)
//  BusWData       out  32  lane-replicated store data
//  BusAck         in   1   completes the request this cycle
//  BusRData       in   32  read data, valid with BusAck
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0; all outputs 0.
//  Reset is async: BusReq drops immediately; later BusAck is ignored.
//  Access = MemReadM | MemWriteM. If both are high, the access is a write.
//  Legality is decided in IDLE only (combinational):
//   - sw needs addr[1:0]==00; sh needs addr[0]==0.
//   - lw needs addr[1:0]==00; lh/lhu need addr[0]==0.
//   - Byte accesses are always aligned.
//   - Reserved size codes are illegal.
//  Illegal access: MisalignM=1, StallM=0, no bus activity, state stays IDLE.
//  FSM, three states IDLE / REQ / DONE:
//   - IDLE, legal access: StallM=1 (combinational).
//     At the edge, register BusAddr, BusBE, BusWData, BusWe and ByteNumM; BusReq<=1; go REQ.
//   - REQ: StallM=1; BusReq and all Bus* outputs stable; counter++ each cycle.
//     BusAck=1: BusReq<=0. If read, ReadDataMTick<=BusRData. Go DONE, counter<=0.
//     Counter==TIMEOUT-1 with no ack: BusReq<=0, BusErrM<=1 for one cycle. If read, ReadDataMTick<=0. Go DONE.
//     Ack wins over timeout in the same cycle.
//   - DONE: StallM=0 so M advances; inputs ignored; go IDLE next cycle. No relaunch of the same instruction.
//  Latency: access seen in cycle N -> BusReq high N+1 -> earliest ack N+1 -> DONE N+2. Minimum 2 stall cycles.
//  BusAck outside REQ is ignored.
//  ReadDataMTick and ByteNumM hold until the next read / launch. Writes never change ReadDataMTick.
//  Byte enables and store lanes (a = addr[1:0]):
//   - sb: BE = 4'b0001<<a, WData = {4{wd[7:0]}}
//   - sh: BE = 4'b0011<<{a[1],1'b0}, WData = {2{wd[15:0]}}
//   - sw: BE = 4'b1111, WData = wd
// TESTING
//  1. lw @0x100; BusAck in first REQ cycle with 0xDEADBEEF -> BusAddr=0x100, BE=1111, StallM 2 cycles, ReadDataMTick=0xDEADBEEF in DONE.
//  2. sb @0x203, wd=0x000000A5 -> BusWe=1, BusAddr=0x200, BE=1000, BusWData=0xA5A5A5A5, ByteNumM=11.
//  3. lh @0x101 and sw @0x102 -> MisalignM=1, StallM=0, BusReq never rises.
//  4. lw, BusAck withheld, TIMEOUT=16 -> BusReq high 16 cycles, BusErrM one pulse, ReadDataMTick=0, pipeline released.
//  5. Reset asserted mid-REQ; BusAck arrives after release -> BusReq/StallM drop async; ack ignored; state IDLE.
//  6. Back-to-back sh @0x2 then lbu @0x7 -> BE 1100 then 1111, ByteNumM 10 then 11, no double launch.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Memory-stage data-bus controller: turns an M-stage load/store into one word-aligned
// bus transaction, stalls until ack or timeout, and hands the raw word to the size converter.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  LoadSizeM,
    input  logic [1:0]  StoreSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataMTick,
    output logic [1:0]  ByteNumM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBE,
    output logic [31:0] BusWData,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  count;
    logic        access, is_write, legal, launch, timed_out;
    logic [1:0]  a;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        a        = ALUResultM[1:0];
        access   = MemReadM | MemWriteM;
        is_write = MemWriteM;
        legal    = 1'b0;
        if (is_write) begin
            unique case (StoreSizeM)
                2'b00:   legal = (a == 2'b00);
                2'b01:   legal = 1'b1;
                2'b10:   legal = ~a[0];
                default: legal = 1'b0;
            endcase
        end else begin
            unique case (LoadSizeM)
                3'b000:          legal = (a == 2'b00);
                3'b001, 3'b010:  legal = 1'b1;
                3'b011, 3'b100:  legal = ~a[0];
                default:         legal = 1'b0;
            endcase
        end
    end

    // Reads enable the whole word; stores replicate the data across every lane.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        if (is_write) begin
            unique case (StoreSizeM)
                2'b01: begin
                    be_next    = 4'b0001 << a;
                    wdata_next = {4{WriteDataM[7:0]}};
                end
                2'b10: begin
                    be_next    = 4'b0011 << {a[1], 1'b0};
                    wdata_next = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // NOTE: state and datapath flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Stall/misalign are combinational; gating with reset makes them drop the moment reset rises.
    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        launch     = 1'b0;
        timed_out  = (count == LAST_COUNT) & ~BusAck;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (access && legal) begin
                        StallM     = 1'b1;
                        launch     = 1'b1;
                        state_next = REQ;
                    end else if (access) begin
                        MisalignM  = 1'b1;
                    end
                end
                REQ: begin
                    StallM = 1'b1;
                    if (BusAck || timed_out) state_next = DONE;
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            BusReq        <= 1'b0;
            BusWe         <= 1'b0;
            BusAddr       <= '0;
            BusBE         <= '0;
            BusWData      <= '0;
            ByteNumM      <= '0;
            ReadDataMTick <= '0;
            BusErrM       <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        BusAddr  <= {ALUResultM[31:2], 2'b00};
                        BusBE    <= be_next;
                        BusWData <= wdata_next;
                        BusWe    <= is_write;
                        ByteNumM <= a;
                        BusReq   <= 1'b1;
                        count    <= '0;
                    end
                end
                REQ: begin
                    if (BusAck) begin
                        BusReq <= 1'b0;
                        count  <= '0;
                        if (!BusWe) ReadDataMTick <= BusRData;
                    end else if (timed_out) begin
                        BusReq  <= 1'b0;
                        BusErrM <= 1'b1;
                        count   <= '0;
                        if (!BusWe) ReadDataMTick <= '0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed self-checking bench for dmem_bus_ctrl: aligned/misaligned loads and stores,
// ack timing, timeout, async reset mid-request and back-to-back accesses.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  LoadSizeM;
    logic [1:0]  StoreSizeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, MisalignM, BusErrM, BusReq, BusWe, BusAck;
    logic [31:0] ReadDataMTick, BusAddr, BusWData, BusRData;
    logic [1:0]  ByteNumM;
    logic [3:0]  BusBE;

    int errors = 0;
    int checks = 0;

    // Per-access observations gathered by run_access.
    int          stall_cnt, req_cnt, err_cnt;
    logic        mis_seen, done_seen;
    logic [31:0] cap_addr, cap_wd, done_rd;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [1:0]  done_bn;

    always #5 clk = ~clk;

    dmem_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .LoadSizeM(LoadSizeM), .StoreSizeM(StoreSizeM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataMTick(ReadDataMTick), .ByteNumM(ByteNumM),
        .MisalignM(MisalignM), .BusErrM(BusErrM),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBE(BusBE),
        .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        MemReadM = 0; MemWriteM = 0; LoadSizeM = 0; StoreSizeM = 0;
        ALUResultM = 0; WriteDataM = 0; BusAck = 0; BusRData = 0;
    endtask

    // Called just after a rising edge; presents one instruction until the stall releases.
    // ack_at selects which REQ cycle (0 = first) sees BusAck; -1 withholds it.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] ls,
                              input logic [1:0] ss, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_at,
                              input logic [31:0] rdata);
        MemReadM = rd; MemWriteM = wr; LoadSizeM = ls; StoreSizeM = ss;
        ALUResultM = addr; WriteDataM = wd;
        stall_cnt = 0; req_cnt = 0; err_cnt = 0; mis_seen = 0; done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            BusAck   = BusReq && (req_cnt == ack_at);
            BusRData = BusAck ? rdata : 32'h0;
            @(negedge clk);
            if (StallM)    stall_cnt++;
            if (MisalignM) mis_seen = 1;
            if (BusErrM)   err_cnt++;
            if (BusReq) begin
                req_cnt++;
                cap_addr = BusAddr; cap_be = BusBE; cap_wd = BusWData; cap_we = BusWe;
            end
            if (!StallM) begin
                done_seen = 1;
                done_rd   = ReadDataMTick;
                done_bn   = ByteNumM;
            end
            @(posedge clk); #1;
        end
        check("stall_released", 32'(done_seen), 32'd1);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #2;
        check("rst_busreq", 32'(BusReq), 0);
        check("rst_stall", 32'(StallM), 0);
        check("rst_rdata", ReadDataMTick, 0);
        check("rst_addr_be", {BusAddr[27:0], BusBE}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // 1: lw @0x100, ack in the first REQ cycle
        run_access(1, 0, 3'b000, 2'b00, 32'h100, 0, 0, 32'hDEADBEEF);
        check("lw_addr", cap_addr, 32'h100);
        check("lw_be", 32'(cap_be), 32'hF);
        check("lw_we", 32'(cap_we), 0);
        check("lw_stalls", stall_cnt, 2);
        check("lw_reqcyc", req_cnt, 1);
        check("lw_rdata", done_rd, 32'hDEADBEEF);

        // 2: sb @0x203; a write must leave ReadDataMTick alone
        run_access(0, 1, 3'b000, 2'b01, 32'h203, 32'h000000A5, 0, 32'h0);
        check("sb_we", 32'(cap_we), 1);
        check("sb_addr", cap_addr, 32'h200);
        check("sb_be", 32'(cap_be), 32'h8);
        check("sb_wdata", cap_wd, 32'hA5A5A5A5);
        check("sb_bytenum", 32'(done_bn), 3);
        check("sb_rdata_kept", done_rd, 32'hDEADBEEF);

        // 3: misaligned lh and sw, plus a reserved load size
        run_access(1, 0, 3'b011, 2'b00, 32'h101, 0, 0, 0);
        check("lh_mis", 32'(mis_seen), 1);
        check("lh_nostall", stall_cnt, 0);
        check("lh_noreq", req_cnt, 0);
        run_access(0, 1, 3'b000, 2'b00, 32'h102, 32'h1, 0, 0);
        check("sw_mis", 32'(mis_seen), 1);
        check("sw_noreq", req_cnt, 0);
        run_access(1, 0, 3'b101, 2'b00, 32'h100, 0, 0, 0);
        check("rsv_mis", 32'(mis_seen), 1);
        check("rsv_noreq", req_cnt, 0);
        check("mis_bytenum_kept", 32'(done_bn), 3);

        // 4: lw with ack withheld -> timeout after 16 REQ cycles
        run_access(1, 0, 3'b000, 2'b00, 32'h40, 0, -1, 0);
        check("to_reqcyc", req_cnt, 16);
        check("to_errpulse", err_cnt, 1);
        check("to_rdata", done_rd, 0);
        check("to_stalls", stall_cnt, 17);
        @(negedge clk);
        check("to_err_cleared", 32'(BusErrM), 0);
        @(posedge clk); #1;

        // Ack in the last allowed REQ cycle beats the timeout
        run_access(1, 0, 3'b000, 2'b00, 32'h44, 0, 15, 32'h0BADF00D);
        check("late_ack_reqcyc", req_cnt, 16);
        check("late_ack_noerr", err_cnt, 0);
        check("late_ack_rdata", done_rd, 32'h0BADF00D);

        // 6: back-to-back sh @0x2 then lbu @0x7
        run_access(0, 1, 3'b000, 2'b10, 32'h2, 32'h00001234, 0, 0);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wd, 32'h12341234);
        check("sh_bytenum", 32'(done_bn), 2);
        check("sh_reqcyc", req_cnt, 1);
        run_access(1, 0, 3'b010, 2'b00, 32'h7, 0, 1, 32'h11223344);
        check("lbu_be", 32'(cap_be), 32'hF);
        check("lbu_addr", cap_addr, 32'h4);
        check("lbu_bytenum", 32'(done_bn), 3);
        check("lbu_reqcyc", req_cnt, 2);
        check("lbu_rdata", done_rd, 32'h11223344);
        @(negedge clk);
        check("no_relaunch", 32'(BusReq), 0);
        @(posedge clk); #1;

        // 5: async reset in the middle of a request; a later ack is ignored
        MemReadM = 1; ALUResultM = 32'h300; LoadSizeM = 3'b000;
        @(posedge clk); #1;
        check("mid_busreq_up", 32'(BusReq), 1);
        @(posedge clk); #3;
        reset = 1;
        #1;
        check("async_busreq", 32'(BusReq), 0);
        check("async_stall", 32'(StallM), 0);
        clear_inputs();
        @(posedge clk); #1;
        reset = 0;
        BusAck = 1; BusRData = 32'hCAFEF00D;
        @(negedge clk);
        check("post_rst_busreq", 32'(BusReq), 0);
        check("post_rst_stall", 32'(StallM), 0);
        @(posedge clk); #1;
        BusAck = 0; BusRData = 0;
        @(negedge clk);
        check("ack_ignored_rdata", ReadDataMTick, 0);
        check("ack_ignored_err", 32'(BusErrM), 0);
        @(posedge clk); #1;

        // Controller is back in IDLE and launches normally
        run_access(1, 0, 3'b001, 2'b00, 32'h1, 0, 0, 32'h000000AB);
        check("after_rst_stalls", stall_cnt, 2);
        check("after_rst_bytenum", 32'(done_bn), 1);
        check("after_rst_rdata", done_rd, 32'h000000AB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
